// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
//   sub_state_t        : control FSM states
//   SUB_DEFAULT_WIDTH  : default operand/result width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned SUB_DEFAULT_WIDTH = 4;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin.
//   x, y  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, D = A - B computed LSB-first, one bit per clock.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : minuend, subtrahend
//   out_valid/out_ready : result handshake, result held until accepted
//   d, borrow           : difference mod 2^WIDTH, final borrow (a < b unsigned)
//   ovf                 : signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_sr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             borrow_q;
  logic             diff, bout;
  logic             load, shift_en, last;

  // Single shared bit cell
  full_subtractor u_fs (
    .diff (diff),
    .bout (bout),
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_q)
  );

  assign in_ready = (state == IDLE);

  // New difference bit enters at the MSB end; after WIDTH shifts bit 0 sits at the LSB
  assign d_sr_nxt = (d_sr >> 1) | (WIDTH'(diff) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, bit counter and running borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      a_sr     <= a;
      b_sr     <= b;
      cnt      <= '0;
      borrow_q <= 1'b0;
    end else if (shift_en) begin
      d_sr     <= d_sr_nxt;
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      borrow_q <= bout;
      // Counter parks at the last bit instead of wrapping
      if (!last) cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers update only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      borrow    <= 1'b0;
    end else if (last) begin
      out_valid <= 1'b1;
      d         <= d_sr_nxt;
      borrow    <= bout;
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // Operand sign bits are shifted away, so keep them for the overflow test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      // The last cell's diff is the result MSB
      if (last) ovf <= (a_msb != b_msb) && (diff != a_msb);
    end
  end
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 with directed vectors.
// Covers the ovf output when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int LATENCY = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, d;
  logic             out_valid;
  logic             out_ready;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation from a negedge in IDLE; hold out_ready low for `hold`
  // cycles after out_valid rises, then accept. Returns at a negedge.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input int hold, output logic [3:0] dv, output logic bo,
                        output int lat);
    check({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        check({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
      end
    end while (!out_valid && lat < 50);
    repeat (hold) @(negedge clk);
    check({tag, "_valid_held"}, 32'(out_valid), 32'd1);
    dv = d;
    bo = borrow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] dv, hold_d;
    logic       bo;
    int         lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    run_op("op9m3", 4'd9, 4'd3, 0, dv, bo, lat);
    check("op9m3_lat", 32'(lat), 32'(LATENCY));
    check("op9m3_d", 32'(dv), 32'h6);
    check("op9m3_b", 32'(bo), 32'd0);

    run_op("op3m9", 4'd3, 4'd9, 0, dv, bo, lat);
    check("op3m9_d", 32'(dv), 32'hA);
    check("op3m9_b", 32'(bo), 32'd1);

    run_op("op5m5", 4'd5, 4'd5, 1, dv, bo, lat);
    check("op5m5_d", 32'(dv), 32'h0);
    check("op5m5_b", 32'(bo), 32'd0);

    run_op("op0m15", 4'd0, 4'd15, 0, dv, bo, lat);
    check("op0m15_d", 32'(dv), 32'h1);
    check("op0m15_b", 32'(bo), 32'd1);

    // Backpressure: 10 - 6 = 4, out_ready low 10 cycles, stray in_valid ignored
    a = 4'd10; b = 4'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_d", 32'(d), 32'h4);
    hold_d = d;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 4'd1; b = 4'd1; in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_d", 32'(d), 32'(hold_d));
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_single_xfer", 32'(out_valid), 32'd0);
      check("bp_idle_rdy", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;

    // Asynchronous reset while computing bit 2
    a = 4'd9; b = 4'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_d", 32'(d), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("arst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("op12m4", 4'd12, 4'd4, 0, dv, bo, lat);
    check("op12m4_lat", 32'(lat), 32'(LATENCY));
    check("op12m4_d", 32'(dv), 32'h8);
    check("op12m4_b", 32'(bo), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf7m8", 4'd7, 4'd8, 0, dv, bo, lat);
    check("ovf7m8_d", 32'(dv), 32'hF);
    check("ovf7m8_ovf", 32'(ovf), 32'd1);
    run_op("ovf4m2", 4'd4, 4'd2, 0, dv, bo, lat);
    check("ovf4m2_d", 32'(dv), 32'h2);
    check("ovf4m2_ovf", 32'(ovf), 32'd0);
`endif

    // Back-to-back random operations with random backpressure
    for (int i = 0; i < 20; i++) begin
      logic [3:0] av, bv, ed;
      av = 4'($urandom);
      bv = 4'($urandom);
      ed = av - bv;
      run_op("rnd", av, bv, int'($urandom_range(0, 3)), dv, bo, lat);
      check("rnd_lat", 32'(lat), 32'(LATENCY));
      check("rnd_d", 32'(dv), 32'(ed));
      check("rnd_b", 32'(bo), 32'(av < bv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
